// File: rtl/picomips_pkg.sv
// Shared picoMIPS types and helpers for the fetch path.
package picomips_pkg;

    localparam int unsigned PICO_ADDR_W  = 6;
    localparam int unsigned PICO_INSTR_W = 16;

    typedef logic [PICO_ADDR_W-1:0]  addr_t;
    typedef logic [PICO_INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RUN,
        HALTED
    } fetch_state_t;

    // Sign extension of the offset to the address width is the identity, so a
    // plain modular add gives ir_pc + sext(offset) mod 2^ADDR_W.
    function automatic addr_t branch_target_calc(
        input addr_t ir_pc,
        input addr_t offset,
        input logic  abs,
        input addr_t target
    );
        if (abs) begin
            return target;
        end
        return ir_pc + offset;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter with load / increment / hold.
// FETCH_PC_WRAP_EN: defined -> PC wraps from the last address to 0;
// undefined -> stepping past the last address marks the PC exhausted and the
// next increment request sets the sticky overflow flag instead.
module pc_reg
    import picomips_pkg::*;
#(
    parameter int unsigned ADDR_W   = PICO_ADDR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              incr_en,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_exhausted,
    output logic              pc_overflow
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_d, pc_q;

`ifdef FETCH_PC_WRAP_EN

    // Next PC: load wins over increment; increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end else if (incr_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_exhausted = 1'b0;
    assign pc_overflow  = 1'b0;

`else

    localparam logic [ADDR_W-1:0] LAST_PC = '1;

    logic end_d, end_q;
    logic ovf_d, ovf_q;

    // Next PC: the PC parks on the last address with end_q set rather than
    // wrapping, so a later increment request can be turned into overflow.
    always_comb begin
        pc_d  = pc_q;
        end_d = end_q;
        ovf_d = ovf_q;
        if (load_en) begin
            pc_d  = load_val;
            end_d = 1'b0;
        end else if (incr_en) begin
            if (end_q) begin
                ovf_d = 1'b1;
            end else if (pc_q == LAST_PC) begin
                end_d = 1'b1;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // PC, end-of-memory and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_VAL;
            end_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            end_q <= end_d;
            ovf_q <= ovf_d;
        end
    end

    assign pc_exhausted = end_q;
    assign pc_overflow  = ovf_q;

`endif

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// picoMIPS program counter and instruction-fetch controller.
// End-of-memory behaviour selected by FETCH_PC_WRAP_EN (see pc_reg).
module fetch_sequencer
    import picomips_pkg::*;
#(
    parameter int unsigned ADDR_W   = PICO_ADDR_W,
    parameter int unsigned INSTR_W  = PICO_INSTR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_en,
    input  logic               branch_abs,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    output logic               running,
    output logic               pc_overflow
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

    fetch_state_t       state_d, state_q;
    logic [INSTR_W-1:0] ir_d, ir_q;
    logic [ADDR_W-1:0]  ir_pc_d, ir_pc_q;
    logic               ir_valid_d, ir_valid_q;

    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               pc_incr;
    logic [ADDR_W-1:0]  pc;
    logic               pc_exhausted;
    logic [ADDR_W-1:0]  target;

    assign target = branch_target_calc(ir_pc_q, branch_offset, branch_abs, branch_target);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .reset        (reset),
        .load_en      (pc_load),
        .load_val     (pc_load_val),
        .incr_en      (pc_incr),
        .pc           (pc),
        .pc_exhausted (pc_exhausted),
        .pc_overflow  (pc_overflow)
    );

    // Next-state, IR and PC-control decode; RUN priority halt > branch > stall > advance.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        pc_load     = 1'b0;
        pc_load_val = RESET_VAL;
        pc_incr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ir_valid_d = 1'b0;
                if (start) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d       = instruction;
                ir_pc_d    = pc;
                ir_valid_d = 1'b1;
                pc_incr    = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (halt) begin
                    ir_valid_d = 1'b0;
                    state_d    = HALTED;
                end else if (branch_en) begin
                    pc_load     = 1'b1;
                    pc_load_val = target;
                    ir_valid_d  = 1'b0;
                    state_d     = FETCH;
                end else if (stall) begin
                    state_d = RUN;
                end else if (pc_exhausted) begin
                    // Last word already executed: request the increment so
                    // pc_reg raises overflow, and stop.
                    pc_incr    = 1'b1;
                    ir_valid_d = 1'b0;
                    state_d    = HALTED;
                end else begin
                    ir_d       = instruction;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_incr    = 1'b1;
                end
            end
            HALTED: begin
                ir_valid_d = 1'b0;
                if (start) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d    = IDLE;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // State and instruction register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign address  = pc;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign running  = (state_q == FETCH) || (state_q == RUN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default and FETCH_PC_WRAP_EN builds).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_en;
    logic        branch_abs;
    logic [5:0]  branch_offset;
    logic [5:0]  branch_target;
    logic        halt;
    logic [5:0]  address;
    logic [15:0] instruction;
    logic [15:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        running;
    logic        pc_overflow;

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer #(
        .ADDR_W   (6),
        .INSTR_W  (16),
        .RESET_PC (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_abs    (branch_abs),
        .branch_offset (branch_offset),
        .branch_target (branch_target),
        .halt          (halt),
        .address       (address),
        .instruction   (instruction),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .running       (running),
        .pc_overflow   (pc_overflow)
    );

    always #5 clk = ~clk;

    // Program memory model: every word encodes its own address.
    function automatic logic [15:0] mem_word(input logic [5:0] a);
        logic [3:0] lo;
        lo = ~a[3:0];
        return {4'hB, 2'b00, a, lo};
    endfunction

    always_comb instruction = mem_word(address);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks a valid IR fetched from address a, with the PC one ahead.
    task automatic chk_ir(input string tag, input logic [5:0] a, input logic [5:0] next_addr);
        chk({tag, "_ir_pc"}, 16'(ir_pc), 16'(a));
        chk({tag, "_ir"}, ir, mem_word(a));
        chk({tag, "_valid"}, 16'(ir_valid), 16'd1);
        chk({tag, "_addr"}, 16'(address), 16'(next_addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
        branch_en = 1'b0; branch_abs = 1'b0;
        branch_offset = '0; branch_target = '0;

        // Reset and start
        step(); step();
        chk("rst_valid", 16'(ir_valid), 16'd0);
        chk("rst_addr", 16'(address), 16'd0);
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_ir", ir, 16'd0);
        chk("rst_ir_pc", 16'(ir_pc), 16'd0);
        chk("rst_ovf", 16'(pc_overflow), 16'd0);
        reset = 1'b1;
        step();
        chk("idle_valid", 16'(ir_valid), 16'd0);
        chk("idle_running", 16'(running), 16'd0);
        chk("idle_addr", 16'(address), 16'd0);
        start = 1'b1;
        step();
        chk("start_running", 16'(running), 16'd1);
        chk("start_valid", 16'(ir_valid), 16'd0);
        chk("start_addr", 16'(address), 16'd0);
        start = 1'b0;
        step(); chk_ir("seq0", 6'd0, 6'd1);
        step(); chk_ir("seq1", 6'd1, 6'd2);
        step(); chk_ir("seq2", 6'd2, 6'd3);

        // Stall for three cycles at ir_pc=2
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_ir("stall", 6'd2, 6'd3);
        end
        stall = 1'b0;
        step(); chk_ir("seq3", 6'd3, 6'd4);
        step(); chk_ir("seq4", 6'd4, 6'd5);
        step(); chk_ir("seq5", 6'd5, 6'd6);

        // Relative branch of -3 from ir_pc=5
        branch_en = 1'b1; branch_abs = 1'b0; branch_offset = 6'b111101;
        step();
        chk("rel_bubble_valid", 16'(ir_valid), 16'd0);
        chk("rel_bubble_addr", 16'(address), 16'd2);
        chk("rel_bubble_running", 16'(running), 16'd1);
        branch_en = 1'b0;
        step(); chk_ir("rel_tgt", 6'd2, 6'd3);

        // Absolute branch with simultaneous stall; stall also held through FETCH
        branch_en = 1'b1; branch_abs = 1'b1; branch_target = 6'd40; stall = 1'b1;
        step();
        chk("abs_bubble_addr", 16'(address), 16'd40);
        chk("abs_bubble_valid", 16'(ir_valid), 16'd0);
        branch_en = 1'b0;
        step(); chk_ir("abs_tgt", 6'd40, 6'd41);
        stall = 1'b0;

        // Halt together with branch and stall: halt wins
        halt = 1'b1; branch_en = 1'b1; branch_abs = 1'b1; branch_target = 6'd10; stall = 1'b1;
        step();
        chk("halt_running", 16'(running), 16'd0);
        chk("halt_valid", 16'(ir_valid), 16'd0);
        chk("halt_addr", 16'(address), 16'd41);
        halt = 1'b0; branch_en = 1'b0; stall = 1'b0;
        step();
        chk("halted_addr", 16'(address), 16'd41);
        chk("halted_running", 16'(running), 16'd0);

        // Restart from HALTED at RESET_PC
        start = 1'b1;
        step();
        chk("restart_running", 16'(running), 16'd1);
        chk("restart_addr", 16'(address), 16'd0);
        chk("restart_valid", 16'(ir_valid), 16'd0);
        start = 1'b0;
        step(); chk_ir("restart0", 6'd0, 6'd1);

        // Branch taken on the last instruction, target wraps (63 + 2 = 1)
        branch_en = 1'b1; branch_abs = 1'b1; branch_target = 6'd62;
        step();
        chk("to62_addr", 16'(address), 16'd62);
        branch_en = 1'b0;
        step(); chk_ir("at62", 6'd62, 6'd63);
`ifdef FETCH_PC_WRAP_EN
        step(); chk_ir("at63", 6'd63, 6'd0);
`else
        step(); chk_ir("at63", 6'd63, 6'd63);
`endif
        branch_en = 1'b1; branch_abs = 1'b0; branch_offset = 6'd2;
        step();
        chk("lastbr_valid", 16'(ir_valid), 16'd0);
        chk("lastbr_addr", 16'(address), 16'd1);
        chk("lastbr_ovf", 16'(pc_overflow), 16'd0);
        chk("lastbr_running", 16'(running), 16'd1);
        branch_en = 1'b0;
        step(); chk_ir("lastbr_tgt", 6'd1, 6'd2);

        // Run sequentially off the end of memory
        branch_en = 1'b1; branch_abs = 1'b1; branch_target = 6'd61;
        step();
        branch_en = 1'b0;
        step(); chk_ir("end61", 6'd61, 6'd62);
        step(); chk_ir("end62", 6'd62, 6'd63);
        step();
        chk("end63_ir_pc", 16'(ir_pc), 16'd63);
        chk("end63_ir", ir, mem_word(6'd63));
        step();
`ifdef FETCH_PC_WRAP_EN
        chk_ir("wrap0", 6'd0, 6'd1);
        chk("wrap_ovf", 16'(pc_overflow), 16'd0);
        chk("wrap_running", 16'(running), 16'd1);
`else
        chk("ovf_flag", 16'(pc_overflow), 16'd1);
        chk("ovf_valid", 16'(ir_valid), 16'd0);
        chk("ovf_running", 16'(running), 16'd0);
        step();
        chk("ovf_sticky", 16'(pc_overflow), 16'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovf_restart_sticky", 16'(pc_overflow), 16'd1);
        step(); chk_ir("ovf_restart0", 6'd0, 6'd1);
`endif

        // Reset asserted in the bubble cycle after a branch
        branch_en = 1'b1; branch_abs = 1'b1; branch_target = 6'd20;
        step();
        chk("mid_bubble_addr", 16'(address), 16'd20);
        chk("mid_bubble_valid", 16'(ir_valid), 16'd0);
        reset = 1'b0; stall = 1'b1;
        step();
        chk("midrst_running", 16'(running), 16'd0);
        chk("midrst_addr", 16'(address), 16'd0);
        chk("midrst_ir", ir, 16'd0);
        chk("midrst_ir_pc", 16'(ir_pc), 16'd0);
        chk("midrst_valid", 16'(ir_valid), 16'd0);
        chk("midrst_ovf", 16'(pc_overflow), 16'd0);
        reset = 1'b1; branch_en = 1'b0; stall = 1'b0;
        step(); step();
        chk("postrst_running", 16'(running), 16'd0);
        chk("postrst_valid", 16'(ir_valid), 16'd0);
        chk("postrst_addr", 16'(address), 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); chk_ir("resume0", 6'd0, 6'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
